// File: rtl/xbox_xlr_host_regs_pkg.sv
// Shared types and helpers for the XBOX accelerator host register bank.
package xbox_host_regs_pkg;

  localparam int NUM_HOST_REGS = 32;
  localparam int HOST_REG_W    = 32;

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} host_regs_state_t;

  typedef logic [NUM_HOST_REGS-1:0][HOST_REG_W-1:0] host_regs_arr_t;

  // Replace only the bytes whose strobe is set.
  function automatic logic [HOST_REG_W-1:0] byte_merge(
    input logic [HOST_REG_W-1:0]   old_val,
    input logic [HOST_REG_W-1:0]   wdata,
    input logic [HOST_REG_W/8-1:0] strb
  );
    logic [HOST_REG_W-1:0] merged;
    merged = old_val;
    for (int k = 0; k < HOST_REG_W/8; k++) begin
      if (strb[k]) merged[8*k +: 8] = wdata[8*k +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/xbox_xlr_host_regs_if.sv
// APB bus bundle between the XBOX segment master and a host register bank.
interface xbox_xlr_host_regs_if #(
  parameter int ADDR_W = 12
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata;
  logic [3:0]        pstrb;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/xbox_xlr_host_regs_fsm.sv
// APB slave handshake: setup/access sequencing, wait-state counter,
// completion strobe and address-decode error.
module xbox_apb_slv_fsm
  import xbox_host_regs_pkg::*;
#(
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic [ADDR_W-1:7] paddr_hi,
  input  logic [1:0]        paddr_lo,
  output logic              pready,
  output logic              complete,
  output logic              slv_err
);

  localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

  host_regs_state_t state, state_next;
  logic [3:0]       cnt, cnt_next;
  logic             addr_err;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pready     = 1'b0;
    unique case (state)
      IDLE: begin
        if (psel && !penable) begin
          state_next = ACCESS;
          cnt_next   = WS_CNT;
        end
      end
      ACCESS: begin
        pready = (cnt == '0);
        if (!psel) begin
          state_next = IDLE;
        end else if (cnt == '0) begin
          if (penable) state_next = IDLE;
        end else if (penable) begin
          cnt_next = cnt - 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign addr_err = (paddr_hi != '0) || (paddr_lo != '0);
  assign complete = psel && penable && pready;
  assign slv_err  = complete && addr_err;

endmodule

// File: rtl/xbox_xlr_host_regs.sv
// Host command/status register bank in front of one XBOX accelerator.
// Optional build macro: XBOX_HOST_REGS_SELF_CLEAR_EN (reg 0 becomes self-clearing).
module xbox_xlr_host_regs
  import xbox_host_regs_pkg::*;
#(
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  xbox_xlr_host_regs_if.slave  bus,
  output host_regs_arr_t       host_regs,
  output logic [31:0]          host_regs_valid_pulse,
  input  host_regs_arr_t       host_regs_data_out,
  input  logic [31:0]          host_regs_valid_out
);

  logic        pready;
  logic        complete;
  logic        slv_err;
  logic        wr_fire;
  logic        show_rd;
  logic [4:0]  idx;
  logic [31:0] rd_value;
  logic [31:0] prdata_q;

  xbox_apb_slv_fsm #(
    .WAIT_STATES (WAIT_STATES),
    .ADDR_W      (ADDR_W)
  ) u_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .psel     (bus.psel),
    .penable  (bus.penable),
    .paddr_hi (bus.paddr[ADDR_W-1:7]),
    .paddr_lo (bus.paddr[1:0]),
    .pready   (pready),
    .complete (complete),
    .slv_err  (slv_err)
  );

  assign idx     = bus.paddr[6:2];
  assign wr_fire = complete && bus.pwrite && !slv_err;
  // Any errored completion, read or write, drives and holds zero on prdata.
  assign show_rd = complete && (!bus.pwrite || slv_err);

  always_comb begin
    rd_value = '0;
    if (!slv_err) begin
      rd_value = host_regs_valid_out[idx] ? host_regs_data_out[idx] : host_regs[idx];
    end
  end

  assign bus.pready  = pready;
  assign bus.pslverr = slv_err;
  assign bus.prdata  = show_rd ? rd_value : prdata_q;

  // NOTE: the register array is reset because the accelerator consumes it
  // directly; an unreset command register could fire spurious work.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      host_regs             <= '0;
      host_regs_valid_pulse <= '0;
      prdata_q              <= '0;
    end else begin
      host_regs_valid_pulse <= '0;
`ifdef XBOX_HOST_REGS_SELF_CLEAR_EN
      if (host_regs_valid_pulse[0]) host_regs[0] <= '0;
`endif
      if (wr_fire) begin
        host_regs[idx]        <= byte_merge(host_regs[idx], bus.pwdata, bus.pstrb);
        host_regs_valid_pulse <= 32'd1 << idx;
      end
      if (show_rd) prdata_q <= rd_value;
    end
  end

endmodule

// File: tb/tb_xbox_xlr_host_regs.sv
// Self-checking bench: two banks (0 and 3 wait states) against a behavioural model.
module tb_xbox_xlr_host_regs;
  import xbox_host_regs_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel_a = 1'b0, psel_b = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;

  host_regs_arr_t regs_a, regs_b, data_out;
  logic [31:0]    pulse_a, pulse_b, valid_out;

  always #5 clk = ~clk;

  xbox_xlr_host_regs_if #(.ADDR_W(12)) bus_a ();
  xbox_xlr_host_regs_if #(.ADDR_W(12)) bus_b ();

  assign bus_a.psel = psel_a;   assign bus_b.psel = psel_b;
  assign bus_a.penable = penable; assign bus_b.penable = penable;
  assign bus_a.pwrite = pwrite; assign bus_b.pwrite = pwrite;
  assign bus_a.paddr = paddr;   assign bus_b.paddr = paddr;
  assign bus_a.pwdata = pwdata; assign bus_b.pwdata = pwdata;
  assign bus_a.pstrb = pstrb;   assign bus_b.pstrb = pstrb;

  xbox_xlr_host_regs #(.WAIT_STATES(0), .ADDR_W(12)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .host_regs(regs_a),
    .host_regs_valid_pulse(pulse_a), .host_regs_data_out(data_out),
    .host_regs_valid_out(valid_out)
  );

  xbox_xlr_host_regs #(.WAIT_STATES(3), .ADDR_W(12)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .host_regs(regs_b),
    .host_regs_valid_pulse(pulse_b), .host_regs_data_out(data_out),
    .host_regs_valid_out(valid_out)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] model [2][32];
  logic [31:0] last_prd [2];

  typedef struct {
    bit          d;
    logic [11:0] addr;
    bit          wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    bit          exp_err;
    logic [31:0] exp_val;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dut_reg(input bit d, input int i);
    return d ? regs_b[i] : regs_a[i];
  endfunction

  task automatic check_regs(input string tag);
    for (int d = 0; d < 2; d++) begin
      int bad = 0;
      for (int i = 31; i >= 0; i--) if (dut_reg(d[0], i) !== model[d][i]) bad = i;
      check($sformatf("%s regs%0d[%0d]", tag, d, bad), dut_reg(d[0], bad), model[d][bad]);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      last_prd[d] = '0;
      for (int i = 0; i < 32; i++) model[d][i] = '0;
    end
  endtask

  // One full APB transfer on bank d, sampling half a cycle away from edges.
  task automatic apb_xfer(input bit d, input logic [11:0] addr, input bit wr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          output logic [31:0] rdata, output logic err, output int waits,
                          output logic [31:0] pulse1, output logic [31:0] pulse2,
                          output logic [31:0] val1, output logic [31:0] val2,
                          output logic [31:0] rd_hold);
    int i;
    i = int'(addr[6:2]);
    @(negedge clk);
    psel_a = !d; psel_b = d; penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
    @(negedge clk);
    penable = 1'b1;
    #1;
    waits = 0;
    while (!(d ? bus_b.pready : bus_a.pready) && waits < 40) begin
      waits++;
      @(negedge clk); #1;
    end
    rdata = d ? bus_b.prdata : bus_a.prdata;
    err   = d ? bus_b.pslverr : bus_a.pslverr;
    @(negedge clk);
    psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
    #1;
    pulse1  = d ? pulse_b : pulse_a;
    val1    = dut_reg(d, i);
    rd_hold = d ? bus_b.prdata : bus_a.prdata;
    @(negedge clk); #1;
    pulse2 = d ? pulse_b : pulse_a;
    val2   = dut_reg(d, i);
  endtask

  // Transfer plus all checks derived from the model.
  task automatic do_xfer(input bit d, input logic [11:0] addr, input bit wr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         output logic [31:0] rdata, output logic err, output logic [31:0] val1);
    int          i, waits;
    bit          exp_err;
    logic [31:0] exp_rd, exp_v1, exp_hold, pulse1, pulse2, val2, rd_hold, exp_pulse;
    i       = int'(addr[6:2]);
    exp_err = (addr[11:7] != 0) || (addr[1:0] != 0);
    exp_rd  = exp_err ? 32'h0 : (valid_out[i] ? data_out[i] : model[d][i]);
    apb_xfer(d, addr, wr, wdata, strb, rdata, err, waits, pulse1, pulse2, val1, val2, rd_hold);
    if (wr && !exp_err) begin
      for (int k = 0; k < 4; k++) if (strb[k]) model[d][i][8*k +: 8] = wdata[8*k +: 8];
    end
    exp_v1    = model[d][i];
    exp_pulse = (wr && !exp_err) ? (32'd1 << i) : 32'h0;
`ifdef XBOX_HOST_REGS_SELF_CLEAR_EN
    if (wr && !exp_err && i == 0) model[d][0] = '0;
`endif
    exp_hold = (!wr || exp_err) ? exp_rd : last_prd[d];
    last_prd[d] = exp_hold;
    check("waits", 32'(waits), d ? 32'd3 : 32'd0);
    check("pslverr", {31'b0, err}, {31'b0, exp_err});
    if (!wr || exp_err) check("prdata", rdata, exp_rd);
    check("prdata_hold", rd_hold, exp_hold);
    check("pulse", pulse1, exp_pulse);
    check("pulse_clear", pulse2, 32'h0);
    check("reg_next", val1, exp_v1);
    check("reg_later", val2, model[d][i]);
    check_regs("xfer");
  endtask

  initial begin
    logic [31:0] rdata, val1;
    logic        err;

    vecs[0]  = '{1'b0, 12'h00C, 1'b1, 32'hDEADBEEF, 4'hF, 1'b0, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 12'h014, 1'b1, 32'h11223344, 4'hF, 1'b0, 32'h11223344};
    vecs[2]  = '{1'b0, 12'h014, 1'b1, 32'hAABBCCDD, 4'h5, 1'b0, 32'h11BB33DD};
    vecs[3]  = '{1'b0, 12'h01C, 1'b1, 32'h00000005, 4'hF, 1'b0, 32'h00000005};
    vecs[4]  = '{1'b0, 12'h014, 1'b0, 32'h0,        4'h0, 1'b0, 32'h11BB33DD};
    vecs[5]  = '{1'b1, 12'h080, 1'b1, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0};
    vecs[6]  = '{1'b1, 12'h00D, 1'b0, 32'h0,        4'h0, 1'b1, 32'h0};
    vecs[7]  = '{1'b1, 12'h008, 1'b1, 32'hCAFEF00D, 4'h0, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 12'h008, 1'b1, 32'hCAFEF00D, 4'hC, 1'b0, 32'hCAFE0000};
    vecs[9]  = '{1'b0, 12'h7FC, 1'b0, 32'h0,        4'h0, 1'b1, 32'h0};
    vecs[10] = '{1'b0, 12'h07C, 1'b1, 32'h13579BDF, 4'h3, 1'b0, 32'h00009BDF};
    vecs[11] = '{1'b0, 12'h07C, 1'b0, 32'h0,        4'h0, 1'b0, 32'h00009BDF};

    valid_out = '0;
    for (int i = 0; i < 32; i++) data_out[i] = $urandom;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst pready_a", {31'b0, bus_a.pready}, 32'h0);
    check("rst pslverr_b", {31'b0, bus_b.pslverr}, 32'h0);
    check("rst prdata_a", bus_a.prdata, 32'h0);
    check("rst pulse_b", pulse_b, 32'h0);
    check_regs("rst");
    rst_n = 1'b1;

    // Directed vector table
    foreach (vecs[n]) begin
      do_xfer(vecs[n].d, vecs[n].addr, vecs[n].wr, vecs[n].wdata, vecs[n].strb, rdata, err, val1);
      check($sformatf("vec%0d err", n), {31'b0, err}, {31'b0, vecs[n].exp_err});
      check($sformatf("vec%0d val", n), (vecs[n].wr && !vecs[n].exp_err) ? val1 : rdata,
            vecs[n].exp_val);
    end

    // Accelerator-owned readback selection on reg 7
    valid_out[7] = 1'b1; data_out[7] = 32'h12345678;
    do_xfer(1'b0, 12'h01C, 1'b0, 32'h0, 4'h0, rdata, err, val1);
    check("rd7 accel", rdata, 32'h12345678);
    valid_out[7] = 1'b0;
    do_xfer(1'b0, 12'h01C, 1'b0, 32'h0, 4'h0, rdata, err, val1);
    check("rd7 host", rdata, 32'h00000005);

    // Reset during a wait state of a write to reg 2 on the 3-wait-state bank
    @(negedge clk);
    psel_b = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h008;
    pwdata = 32'h55AA55AA; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    #1;
    check("abort pready", {31'b0, bus_b.pready}, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; psel_b = 1'b0; penable = 1'b0;
    model_reset();
    #1;
    check("abort reg2", regs_b[2], 32'h0);
    check("abort pulse", pulse_b, 32'h0);
    check("abort pready_idle", {31'b0, bus_b.pready}, 32'h0);
    @(negedge clk); #1;
    check("abort pulse_late", pulse_b, 32'h0);
    do_xfer(1'b1, 12'h008, 1'b1, 32'h0BADF00D, 4'hF, rdata, err, val1);
    check("after abort", val1, 32'h0BADF00D);

    // Command register 0: self-clearing only when the feature is built in
    do_xfer(1'b0, 12'h000, 1'b1, 32'h00000001, 4'hF, rdata, err, val1);
    check("reg0 pulse-cycle value", val1, 32'h1);
    do_xfer(1'b0, 12'h000, 1'b0, 32'h0, 4'h0, rdata, err, val1);
`ifdef XBOX_HOST_REGS_SELF_CLEAR_EN
    check("reg0 readback", rdata, 32'h0);
`else
    check("reg0 readback", rdata, 32'h1);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 60; n++) begin
      bit          d, wr;
      logic [11:0] addr;
      d    = 1'($urandom_range(0, 1));
      wr   = 1'($urandom_range(0, 1));
      addr = {5'b0, 5'($urandom_range(0, 31)), 2'b00};
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 1) addr = addr | (12'h080 << $urandom_range(0, 4));
        else                           addr = addr | (12'h001 << $urandom_range(0, 1));
      end
      valid_out = $urandom;
      for (int i = 0; i < 32; i++) data_out[i] = $urandom;
      do_xfer(d, addr, wr, $urandom, 4'($urandom_range(0, 15)), rdata, err, val1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
